settle_monitor: RTL and testbench

//  Synthesizable, multi-channel settling checker for on-chip self-test of the balance loop.

---
 rtl/settle_monitor_if.sv | 30 +++
 rtl/settle_monitor.sv | 164 ++++++++++++++++
 tb/tb_settle_monitor.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/settle_monitor_if.sv
// Handshake/data bundle for the settling monitor.
// Master drives config and samples; slave returns status and verdicts.
interface settle_monitor_if #(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 16
);
  logic                    start;
  logic                    abort;
  logic                    smpl_en;
  logic [NUM_CH*WIDTH-1:0] sig;
  logic [NUM_CH*WIDTH-1:0] target;
  logic [WIDTH-1:0]        tol;
  logic [7:0]              max_win;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [NUM_CH-1:0]       ch_pass;
  logic [NUM_CH*WIDTH-1:0] avg;
  logic [7:0]              win_cnt;

  modport master (
    output start, abort, smpl_en, sig, target, tol, max_win,
    input  busy, done, pass, ch_pass, avg, win_cnt
  );

  modport slave (
    input  start, abort, smpl_en, sig, target, tol, max_win,
    output busy, done, pass, ch_pass, avg, win_cnt
  );
endinterface

// File: rtl/settle_monitor.sv
// Multi-channel settling checker: windowed averages compared to
// per-channel targets, retried up to max_win windows.
module settle_monitor #(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 16,
  parameter int LOG_SAMPLES = 10
) (
  input logic             clk,
  input logic             rst_n,
  settle_monitor_if.slave bus
);
  localparam int AW = WIDTH + LOG_SAMPLES;
  localparam int PW = NUM_CH * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EVAL
  } state_e;

  state_e                 state_q, state_d;
  logic signed [AW-1:0]   acc_q [NUM_CH];
  logic signed [AW-1:0]   acc_d [NUM_CH];
  logic [LOG_SAMPLES-1:0] cnt_q, cnt_d;
  logic [PW-1:0]          tgt_q, tgt_d;
  logic [WIDTH-1:0]       tol_q, tol_d;
  logic [7:0]             mw_q, mw_d;
  logic [7:0]             win_q, win_d;
  logic [PW-1:0]          avg_q, avg_d;
  logic [NUM_CH-1:0]      chp_q, chp_d;
  logic                   pass_q, pass_d;
  logic                   done_q, done_d;

  logic [PW-1:0]          avg_w;
  logic [NUM_CH-1:0]      chp_w;
  logic [WIDTH:0]         dif;
  logic [WIDTH:0]         mag;
  logic [7:0]             win_inc;
  logic [7:0]             mw_eff;

  // Upper WIDTH bits of the accumulator are the floor-divided average.
  always_comb begin
    avg_w = '0;
    chp_w = '0;
    dif   = '0;
    mag   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      avg_w[k*WIDTH +: WIDTH] = acc_q[k][LOG_SAMPLES +: WIDTH];
      dif = {avg_w[k*WIDTH+WIDTH-1], avg_w[k*WIDTH +: WIDTH]}
          - {tgt_q[k*WIDTH+WIDTH-1], tgt_q[k*WIDTH +: WIDTH]};
      mag = dif[WIDTH] ? -dif : dif;
      chp_w[k] = (mag <= {1'b0, tol_q});
    end
  end

  assign win_inc = win_q + 8'd1;
  assign mw_eff  = (mw_q == 8'd0) ? 8'd1 : mw_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    tol_d   = tol_q;
    mw_d    = mw_q;
    win_d   = win_q;
    avg_d   = avg_q;
    chp_d   = chp_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          tgt_d   = bus.target;
          tol_d   = bus.tol;
          mw_d    = bus.max_win;
          cnt_d   = '0;
          win_d   = '0;
          pass_d  = 1'b0;
          chp_d   = '0;
          for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
        end
      end
      ACCUM: begin
        if (bus.smpl_en) begin
          for (int k = 0; k < NUM_CH; k++)
            acc_d[k] = acc_q[k]
                     + AW'($signed(bus.sig[k*WIDTH +: WIDTH]));
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = EVAL;
        end
      end
      EVAL: begin
        avg_d = avg_w;
        chp_d = chp_w;
        win_d = win_inc;
        cnt_d = '0;
        for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
        if (&chp_w) begin
          pass_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (win_inc >= mw_eff) begin
          pass_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort cancels everything, including a verdict being formed.
    if (bus.abort) begin
      state_d = IDLE;
      pass_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
      avg_d   = avg_q;
      chp_d   = (state_q == IDLE) ? chp_q : chp_q;
      win_d   = win_q;
      tgt_d   = tgt_q;
      tol_d   = tol_q;
      mw_d    = mw_q;
      for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      tol_q   <= '0;
      mw_q    <= '0;
      win_q   <= '0;
      avg_q   <= '0;
      chp_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= acc_d[k];
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      tol_q   <= tol_d;
      mw_q    <= mw_d;
      win_q   <= win_d;
      avg_q   <= avg_d;
      chp_q   <= chp_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.ch_pass = chp_q;
  assign bus.avg     = avg_q;
  assign bus.win_cnt = win_q;
endmodule

// File: tb/tb_settle_monitor.sv
// Randomized bench for settle_monitor against a window-level
// reference model (floor averages, retry/verdict rules).
module tb_settle_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  int   base[2];
  int   jit;
  int   exp_avg[2] = '{0, 0};
  bit [1:0] exp_chp = '0;
  int   exp_win = 0;
  bit   exp_pass = 1'b0;

  always #5 clk = ~clk;

  settle_monitor_if #(.NUM_CH(2), .WIDTH(16)) bus_if ();

  settle_monitor #(
    .NUM_CH(2), .WIDTH(16), .LOG_SAMPLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  task automatic check(input string tag, input longint got,
                       input longint exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor16(input longint s);
    longint q;
    q = s / 16;
    if ((s % 16) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  task automatic check_result(input string tag);
    check({tag, ".pass"}, bus_if.pass, exp_pass);
    check({tag, ".ch_pass"}, bus_if.ch_pass, exp_chp);
    check({tag, ".avg0"}, $signed(bus_if.avg[15:0]), exp_avg[0]);
    check({tag, ".avg1"}, $signed(bus_if.avg[31:16]), exp_avg[1]);
    check({tag, ".win_cnt"}, bus_if.win_cnt, exp_win);
  endtask

  // mode 0: base+jitter, 1: off-target first window, 2: floor/limit data
  task automatic run_check(input string tag, input int t0, input int t1,
                           input int tolv, input int mw, input int mode,
                           input int period, input int abort_at,
                           input int bstart_at);
    longint sum[2];
    int s[2];
    int tv[2];
    int cnt, win, ev_at, stop_at, n, mwe, d, a;
    bit se, aborted, ok;
    tv[0] = t0;
    tv[1] = t1;
    mwe = (mw == 0) ? 1 : mw;
    sum[0] = 0;
    sum[1] = 0;
    cnt = 0;
    win = 0;
    ev_at = -1;
    stop_at = -1;
    aborted = 1'b0;
    exp_pass = 1'b0;
    exp_chp = '0;
    exp_win = 0;
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      bus_if.start = (n == 0) || (n == bstart_at);
      bus_if.abort = (n == abort_at);
      if (n == 0) begin
        bus_if.target = {t1[15:0], t0[15:0]};
        bus_if.tol = tolv[15:0];
        bus_if.max_win = mw[7:0];
      end else begin
        bus_if.target = $urandom;
        bus_if.tol = 16'($urandom);
        bus_if.max_win = 8'($urandom);
      end
      if (period == 0) se = 1'($urandom);
      else se = (n > 0) && (n % period == 0);
      for (int c = 0; c < 2; c++) begin
        case (mode)
          1: s[c] = (c == 0) ? ((win == 0) ? 200 : 100) : -50;
          2: s[c] = (c == 0) ? ((cnt % 2 == 0) ? -1 : -2) : 32767;
          default:
            s[c] = sat16(base[c] + int'($urandom_range(0, 2 * jit)) - jit);
        endcase
      end
      bus_if.sig = {s[1][15:0], s[0][15:0]};
      bus_if.smpl_en = se;
      if (n == abort_at) begin
        aborted = 1'b1;
        stop_at = n + 1;
      end else if (!aborted && n > 0 && n != ev_at && stop_at < 0 && se) begin
        for (int c = 0; c < 2; c++) sum[c] += s[c];
        cnt++;
        if (cnt == 16) begin
          ok = 1'b1;
          for (int c = 0; c < 2; c++) begin
            a = floor16(sum[c]);
            d = a - tv[c];
            if (d < 0) d = -d;
            exp_avg[c] = a;
            exp_chp[c] = (d <= tolv);
            if (d > tolv) ok = 1'b0;
            sum[c] = 0;
          end
          win++;
          exp_win = win;
          cnt = 0;
          ev_at = n + 1;
          if (ok || win >= mwe) begin
            exp_pass = ok;
            stop_at = n + 2;
          end
        end
      end
      @(negedge clk);
      check({tag, ".done"}, bus_if.done, !aborted && n == stop_at);
      check({tag, ".busy"}, bus_if.busy,
            n >= 1 && (stop_at < 0 || n < stop_at));
      if (!aborted && n == stop_at) break;
      if (aborted && n == abort_at + 20) break;
      if (n > 3000) begin
        check({tag, ".timeout"}, 1, 0);
        break;
      end
      n++;
    end
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.smpl_en = 1'b0;
    check_result(tag);
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    bus_if.smpl_en = 1'b0;
    bus_if.sig = '0;
    bus_if.target = '0;
    bus_if.tol = '0;
    bus_if.max_win = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", bus_if.busy, 0);
    check("rst.done", bus_if.done, 0);
    check_result("rst");
    rst_n = 1'b1;

    base[0] = 100; base[1] = -50; jit = 0;
    run_check("t1", 96, -48, 8, 3, 0, 1, -1, -1);
    run_check("t2", 96, -48, 8, 3, 1, 1, -1, -1);
    base[0] = 10; base[1] = -300; jit = 0;
    run_check("t3", 0, 0, 100, 2, 0, 1, -1, -1);
    run_check("t4a", -2, 32767, 0, 1, 2, 1, -1, -1);
    run_check("t4b", -32768, -32768, 65535, 1, 2, 1, -1, -1);
    run_check("t4c", -32768, -32768, 65534, 1, 2, 1, -1, -1);

    base[0] = 100; base[1] = -50; jit = 3;
    run_check("t5abort", 100, -50, 10, 2, 0, 1, 9, -1);
    run_check("t5clean", 100, -50, 10, 2, 0, 1, -1, -1);

    @(posedge clk);
    #1;
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    bus_if.target = $urandom;
    exp_pass = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5sa.busy", bus_if.busy, 0);
      check("t5sa.done", bus_if.done, 0);
      @(posedge clk);
      #1;
      bus_if.start = 1'b0;
      bus_if.abort = 1'b0;
    end
    check_result("t5sa");

    base[0] = 500; base[1] = 700; jit = 4;
    run_check("t6", 500, 700, 5, 0, 0, 3, -1, 5);

    for (int i = 0; i < 10; i++) begin
      int t0, t1, tl, mw, pr;
      t0 = int'($urandom_range(0, 4000)) - 2000;
      t1 = int'($urandom_range(0, 4000)) - 2000;
      base[0] = t0 + int'($urandom_range(0, 300)) - 150;
      base[1] = t1 + int'($urandom_range(0, 300)) - 150;
      jit = int'($urandom_range(0, 60));
      tl = int'($urandom_range(0, 200));
      mw = int'($urandom_range(0, 4));
      pr = int'($urandom_range(0, 3));
      run_check("rnd", t0, t1, tl, mw, 0, pr, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
